// File: rtl/vetores_pkg.sv
// Shared widths and byte-counter state encoding for the byte-to-word packer.
package vetores_pkg;
  localparam int LARGURA_BYTE      = 8;
  localparam int BYTES_POR_PALAVRA = 4;
  localparam int LARGURA_PALAVRA   = LARGURA_BYTE * BYTES_POR_PALAVRA;

  // The state value doubles as the index of the next byte within the word.
  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    DOIS  = 2'd2,
    TRES  = 2'd3
  } estado_t;
endpackage

// File: rtl/posicionar_byte.sv
// Places one byte in its 32-bit lane and produces the matching one-hot lane mask.
module posicionar_byte
  import vetores_pkg::*;
#(
  parameter int ORDEM_BIG = 1
) (
  input  logic [7:0]  dado_byte,
  input  logic [1:0]  indice,
  output logic [31:0] palavra,
  output logic [3:0]  mascara
);

  logic [1:0] faixa;

  always_comb begin
    faixa   = (ORDEM_BIG != 0) ? (2'd3 - indice) : indice;
    palavra = '0;
    palavra[faixa*LARGURA_BYTE +: LARGURA_BYTE] = dado_byte;
    mascara = 4'b0001 << faixa;
  end

endmodule

// File: rtl/empacotar_bytes.sv
// Packs a byte stream into 32-bit words with lane mask; a word closes on the
// 4th byte or on a byte flagged last, and is held until the consumer takes it.
module empacotar_bytes
  import vetores_pkg::*;
#(
  parameter int ORDEM_BIG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  entrada_byte,
  input  logic        entrada_valida,
  input  logic        entrada_ultimo,
  output logic        entrada_pronta,
  output logic [31:0] saida,
  output logic [3:0]  saida_mascara,
  output logic        saida_ultimo,
  output logic        saida_valida,
  input  logic        saida_pronta
);

  estado_t     estado_q, estado_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  acc_masc_q, acc_masc_d;
  logic [31:0] saida_q, saida_d;
  logic [3:0]  masc_q, masc_d;
  logic        ultimo_q, ultimo_d;
  logic        valida_q, valida_d;

  logic [31:0] palavra_pos;
  logic [3:0]  masc_pos;
  logic        aceita, consome, completa;

  posicionar_byte #(
    .ORDEM_BIG (ORDEM_BIG)
  ) u_posicionar (
    .dado_byte (entrada_byte),
    .indice    (estado_q),
    .palavra   (palavra_pos),
    .mascara   (masc_pos)
  );

  // Acceptance is only possible when the output register is free or draining,
  // so loading it on completion never overwrites an unconsumed word.
  assign entrada_pronta = ~valida_q | saida_pronta;
  assign aceita         = entrada_valida & entrada_pronta;
  assign consome        = valida_q & saida_pronta;
  assign completa       = aceita & ((estado_q == TRES) | entrada_ultimo);

  always_comb begin
    estado_d   = estado_q;
    acc_d      = acc_q;
    acc_masc_d = acc_masc_q;
    saida_d    = saida_q;
    masc_d     = masc_q;
    ultimo_d   = ultimo_q;
    valida_d   = valida_q;

    if (consome) valida_d = 1'b0;

    if (completa) begin
      saida_d    = acc_q | palavra_pos;
      masc_d     = acc_masc_q | masc_pos;
      ultimo_d   = entrada_ultimo;
      valida_d   = 1'b1;
      estado_d   = VAZIO;
      acc_d      = '0;
      acc_masc_d = '0;
    end else if (aceita) begin
      acc_d      = acc_q | palavra_pos;
      acc_masc_d = acc_masc_q | masc_pos;
      estado_d   = estado_t'(estado_q + 2'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= VAZIO;
      acc_q      <= '0;
      acc_masc_q <= '0;
      saida_q    <= '0;
      masc_q     <= '0;
      ultimo_q   <= 1'b0;
      valida_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      acc_q      <= acc_d;
      acc_masc_q <= acc_masc_d;
      saida_q    <= saida_d;
      masc_q     <= masc_d;
      ultimo_q   <= ultimo_d;
      valida_q   <= valida_d;
    end
  end

  assign saida         = saida_q;
  assign saida_mascara = masc_q;
  assign saida_ultimo  = ultimo_q;
  assign saida_valida  = valida_q;

endmodule
